// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory with a valid/ready request and
// response handshake for a RISC-V load/store unit.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
// Without it, low address bits below the access size are ignored.
module dmem_responder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    state_t            state_next;
    logic              access_second;
    logic              accept;

    logic              acc_we;
    logic [2:0]        acc_funct3;
    logic [1:0]        acc_offset;
    logic [ADDR_W-1:0] acc_index;
    logic [31:0]       acc_wdata;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       rd_word;
    logic              funct3_bad;
    logic              acc_misaligned;
    logic              acc_bad;
    logic              unused_addr_bits;

    // Select and extend the addressed byte/half/word of a memory word.
    function automatic logic [31:0] load_format(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Merge right-aligned store data into the selected lanes of a word.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            3'b001: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            3'b010:  r = wdata;
            default: r = word;
        endcase
        return r;
    endfunction

    // Address bits above the word index alias onto the same storage.
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

    assign accept     = req_valid & req_ready;
    assign funct3_bad = acc_we ? (acc_funct3[2] | (acc_funct3[1:0] == 2'b11))
                               : ((acc_funct3[1:0] == 2'b11) | (acc_funct3 == 3'b110));
`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_misaligned = ((acc_funct3[1:0] == 2'b01) & acc_offset[0]) |
                            ((acc_funct3[1:0] == 2'b10) & (acc_offset != 2'b00));
`else
    assign acc_misaligned = 1'b0;
`endif
    assign acc_bad  = funct3_bad | acc_misaligned;
    assign dbg_data = mem[dbg_addr];

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs; ACCESS spans a read cycle and a commit cycle.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ACCESS;
            end
            ACCESS: begin
                if (access_second) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ACCESS phase flag and response registers, held stable through RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            access_second <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
        end else begin
            access_second <= (state == ACCESS) && !access_second;
            if (state == ACCESS && access_second) begin
                resp_err   <= acc_bad;
                resp_rdata <= (acc_bad || acc_we) ? 32'd0
                                                  : load_format(rd_word, acc_funct3, acc_offset);
            end
        end
    end

    // Capture the accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_we     <= req_we;
            acc_funct3 <= req_funct3;
            acc_offset <= req_addr[1:0];
            acc_index  <= req_addr[ADDR_W+1:2];
            acc_wdata  <= req_wdata;
        end
    end

    // Synchronous word read, then read-modify-write commit on the ACCESS->RESP edge.
    always_ff @(posedge clk) begin
        if (state == ACCESS && !access_second)
            rd_word <= mem[acc_index];
        if (state == ACCESS && access_second && acc_we && !acc_bad)
            mem[acc_index] <= store_merge(rd_word, acc_wdata, acc_funct3, acc_offset);
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic
// compared against a byte-addressed little-endian memory model.
module tb_dmem_responder;

    localparam int AW = 6;

    logic          clk;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_bytes [0:(4<<AW)-1];

    dmem_responder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    // Byte-level reference: size from funct3, little-endian assembly, arithmetic sign fix.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int     size;
        int     base;
        bit     legal;
        longint v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3[1:0] != 2'b11 && f3 != 3'b110);
        base  = int'(addr % (4 << AW));
`ifdef DMEM_ALIGN_CHECK_EN
        if (base % size != 0) legal = 1'b0;
`else
        base = base - (base % size);
`endif
        rd = 32'd0;
        er = !legal;
        if (legal && we) begin
            for (int i = 0; i < size; i++) ref_bytes[base+i] = wdata[8*i +: 8];
        end else if (legal) begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_bytes[base+i]) << (8*i);
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1)))
                v -= (longint'(1) << (8*size));
            rd = v[31:0];
        end
    endtask

    // One full transaction: accept, latency, response, optional back-pressure, release.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat;
        @(negedge clk);
        check_val("ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        dbg_addr   = addr[AW+1:2];
        model(we, f3, addr, wdata, exp_rd, exp_er);
        @(posedge clk); #1;
        if (hold == 0) req_valid = 1'b0;
        check_val("ready_busy", req_ready, 0);
        lat = 0;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, 2);
        check_val("rdata", resp_rdata, exp_rd);
        check_val("err", resp_err, exp_er);
        check_val("dbg_commit", dbg_data, ref_word(int'(addr[AW+1:2])));
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", resp_valid, 1);
            check_val("hold_ready", req_ready, 0);
            check_val("hold_rdata", resp_rdata, exp_rd);
            check_val("hold_err", resp_err, exp_er);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_val("release_valid", resp_valid, 0);
        check_val("release_ready", req_ready, 1);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        dbg_addr   = '0;
        #1;
        check_val("rst_ready", req_ready, 1);
        check_val("rst_valid", resp_valid, 0);
        check_val("rst_rdata", resp_rdata, 0);
        check_val("rst_err", resp_err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Fill all words so the model knows every location; upper address bits vary.
        for (int w = 0; w < (1 << AW); w++)
            xact(1'b1, 3'b010, {$urandom_range(0, 255), 24'd0} | (w * 4), $urandom, 0, rd, er);

        xact(1'b1, 3'b010, 32'h10, 32'h80F01234, 0, rd, er);
        check_val("sw_rdata", rd, 32'h0);
        check_val("sw_err", er, 0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
        check_val("lw_10", rd, 32'h80F01234);
        xact(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
        check_val("lb_13", rd, 32'hFFFFFF80);
        xact(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er);
        check_val("lbu_13", rd, 32'h00000080);
        xact(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
        check_val("lh_12", rd, 32'hFFFF80F0);
        xact(1'b0, 3'b101, 32'h10, 32'h0, 0, rd, er);
        check_val("lhu_10", rd, 32'h00001234);
        xact(1'b1, 3'b000, 32'h11, 32'h000000AA, 0, rd, er);
        check_val("sb_dbg", dbg_data, 32'h80F0AA34);
        xact(1'b0, 3'b010, 32'h12, 32'h0, 0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        check_val("lw_mis_rdata", rd, 32'h0);
        check_val("lw_mis_err", er, 1);
`else
        check_val("lw_mis_rdata", rd, 32'h80F0AA34);
        check_val("lw_mis_err", er, 0);
`endif
        xact(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
        check_val("hold_lw", rd, 32'h80F0AA34);

        // Reset pulse while a store sits in ACCESS.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'hDEADBEEF;
        dbg_addr   = 6'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("rst_acc_busy", req_ready, 0);
        rstn = 1'b0;
        #1;
        check_val("rst_acc_valid", resp_valid, 0);
        check_val("rst_acc_ready", req_ready, 1);
        check_val("rst_acc_rdata", resp_rdata, 0);
        check_val("rst_acc_err", resp_err, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_valid", resp_valid, 0);
        check_val("post_rst_ready", req_ready, 1);
        check_val("post_rst_word8", dbg_data, ref_word(8));

        xact(1'b1, 3'b011, 32'h20, 32'h12345678, 0, rd, er);
        check_val("bad_store_err", er, 1);
        check_val("bad_store_rdata", rd, 32'h0);
        check_val("bad_store_word8", dbg_data, ref_word(8));

        // Randomized traffic, including illegal codes and random back-pressure.
        for (int n = 0; n < 300; n++)
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom_range(0, 3), rd, er);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
